// File: rtl/dbg_pkg.sv
// Shared types and constants for the GAT debug monitor: stage FSM encoding,
// identification words and readout register map bases.
package dbg_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} stage_state_e;

  localparam logic [31:0] DBG_MAGIC = 32'd12212204;
  localparam logic [31:0] DBG_BAD   = 32'hDEAD_BEEF;

  localparam int unsigned RD_MAGIC      = 0;
  localparam int unsigned RD_CFG        = 1;
  localparam int unsigned RD_STICKY     = 2;
  localparam int unsigned RD_CAPT_STAT  = 3;
  localparam int unsigned RD_STAGE_BASE = 4;

  function automatic logic [31:0] cfg_word(input int unsigned n_stages,
                                           input int unsigned n_capt,
                                           input int unsigned cnt_w);
    return {8'h0, 8'(n_stages), 8'(n_capt), 8'(cnt_w)};
  endfunction

endpackage

// File: rtl/dbg_stage_tracker.sv
// One monitored vld/rdy pair: sticky flags, IDLE/RUN/DONE latency FSM and a
// saturating valid-event counter.
module dbg_stage_tracker
  import dbg_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             vld_i,
  input  logic             rdy_i,
  output logic             vld_sticky_o,
  output logic             rdy_sticky_o,
  output logic [CNT_W-1:0] latency_o,
  output logic [CNT_W-1:0] event_cnt_o
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  stage_state_e     state_q, state_d;
  logic [CNT_W-1:0] run_q, run_d, lat_q, lat_d, evt_q, evt_d;
  logic [CNT_W-1:0] run_inc;
  logic             vld_st_q, rdy_st_q;

  assign run_inc = (run_q == CntMax) ? run_q : run_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    lat_d   = lat_q;
    evt_d   = (evt_q == CntMax) ? evt_q : evt_q + CNT_W'(vld_i);
    case (state_q)
      ST_IDLE: begin
        if (vld_i && rdy_i) begin
          state_d = ST_DONE;
          lat_d   = '0;
        end else if (vld_i) begin
          state_d = ST_RUN;
          run_d   = '0;
        end
      end
      ST_RUN: begin
        run_d = run_inc;
        // run_q counts cycles since vld, so the completed latency is run_q+1
        if (rdy_i) begin
          state_d = ST_DONE;
          lat_d   = run_inc;
        end
      end
      ST_DONE: begin
        if (vld_i) begin
          state_d = ST_RUN;
          run_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (clr_i) begin
      state_d = ST_IDLE;
      run_d   = '0;
      lat_d   = '0;
      evt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      run_q    <= '0;
      lat_q    <= '0;
      evt_q    <= '0;
      vld_st_q <= 1'b0;
      rdy_st_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      lat_q    <= lat_d;
      evt_q    <= evt_d;
      // a set in the clearing cycle survives so no event is lost
      vld_st_q <= vld_i | (vld_st_q & ~clr_i);
      rdy_st_q <= rdy_i | (rdy_st_q & ~clr_i);
    end
  end

  assign vld_sticky_o = vld_st_q;
  assign rdy_sticky_o = rdy_st_q;
  assign latency_o    = lat_q;
  assign event_cnt_o  = evt_q;

endmodule

// File: rtl/gat_debug_monitor.sv
// Observe-only debug monitor for the GAT pipeline: per-stage trackers, an
// address-triggered capture buffer and a registered readout mux.
module gat_debug_monitor
  import dbg_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_CAPT   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic [NUM_STAGES-1:0]   stage_vld_i,
  input  logic [NUM_STAGES-1:0]   stage_rdy_i,
  input  logic                    trig_en_i,
  input  logic [ADDR_W-1:0]       trig_addr_i,
  input  logic                    mon_strobe_i,
  input  logic [ADDR_W-1:0]       mon_addr_i,
  input  logic [DATA_W-1:0]       mon_data_i,
  input  logic [7:0]              rd_sel_i,
  output logic [31:0]             rd_data_o,
  output logic [2*NUM_STAGES-1:0] sticky_o,
  output logic                    capt_full_o
);

  localparam int unsigned PTR_W = $clog2(NUM_CAPT + 1);

  logic [NUM_STAGES-1:0]            vld_st, rdy_st;
  logic [NUM_STAGES-1:0][CNT_W-1:0] lat, evt;

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    dbg_stage_tracker #(
      .CNT_W(CNT_W)
    ) u_trk (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr_i       (clr_i),
      .vld_i       (stage_vld_i[g]),
      .rdy_i       (stage_rdy_i[g]),
      .vld_sticky_o(vld_st[g]),
      .rdy_sticky_o(rdy_st[g]),
      .latency_o   (lat[g]),
      .event_cnt_o (evt[g])
    );
  end

  assign sticky_o = {vld_st, rdy_st};

  logic [PTR_W-1:0]             wr_ptr_q;
  logic [NUM_CAPT-1:0][31:0]    slot_q;
  logic                         hit;

  assign hit         = trig_en_i & mon_strobe_i & (mon_addr_i == trig_addr_i);
  assign capt_full_o = (wr_ptr_q == PTR_W'(NUM_CAPT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      slot_q   <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      slot_q   <= '0;
    end else if (hit && !capt_full_o) begin
      wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      for (int unsigned j = 0; j < NUM_CAPT; j++) begin
        if (wr_ptr_q == PTR_W'(j)) slot_q[j] <= 32'(mon_data_i);
      end
    end
  end

  logic [31:0] rd_d, rd_q;

  always_comb begin
    rd_d = DBG_BAD;
    if (rd_sel_i == 8'(RD_MAGIC))          rd_d = DBG_MAGIC;
    else if (rd_sel_i == 8'(RD_CFG))       rd_d = cfg_word(NUM_STAGES, NUM_CAPT, CNT_W);
    else if (rd_sel_i == 8'(RD_STICKY))    rd_d = 32'(sticky_o);
    else if (rd_sel_i == 8'(RD_CAPT_STAT)) rd_d = {24'h0, 7'(wr_ptr_q), capt_full_o};
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      if (rd_sel_i == 8'(RD_STAGE_BASE + 2 * i))     rd_d = 32'(lat[i]);
      if (rd_sel_i == 8'(RD_STAGE_BASE + 2 * i + 1)) rd_d = 32'(evt[i]);
    end
    for (int unsigned j = 0; j < NUM_CAPT; j++) begin
      if (rd_sel_i == 8'(RD_STAGE_BASE + 2 * NUM_STAGES + j)) rd_d = slot_q[j];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_q <= '0;
    else        rd_q <= rd_d;
  end

  assign rd_data_o = rd_q;

endmodule
